// File: rtl/riscv_encode.sv
// RV32I field-to-word encoder feeding the instruction-memory write port.
// Optional immediate range checking is enabled by defining RISCV_ENCODE_RANGE_CHECK_EN.
module riscv_encode #(
    parameter int unsigned IMEM_DEPTH = 4096,
    localparam int unsigned AW = $clog2(IMEM_DEPTH),
    localparam int unsigned CW = $clog2(IMEM_DEPTH + 1)
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          clear_in,
    input  logic          req_valid_in,
    output logic          req_ready_out,
    input  logic [2:0]    fmt_in,
    input  logic [6:0]    opcode_in,
    input  logic [2:0]    funct3_in,
    input  logic [6:0]    funct7_in,
    input  logic [4:0]    rd_in,
    input  logic [4:0]    rs1_in,
    input  logic [4:0]    rs2_in,
    input  logic [31:0]   imm_in,
    output logic          imem_we_out,
    input  logic          imem_ready_in,
    output logic [AW-1:0] imem_addr_out,
    output logic [31:0]   imem_data_out,
    output logic [CW-1:0] count_out,
    output logic          full_out,
    output logic          error_out
);

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    fmt_e          fmt;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_nxt;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   data_q;
    logic          err_q;
    logic          complete;
    logic          accept;
    logic          full_pending;
    logic          is_shift;
    logic          fmt_ok;
    logic          imm_ok;
    logic [31:0]   enc_word;

    assign fmt      = fmt_e'(fmt_in);
    assign is_shift = (opcode_in == 7'b0010011) &&
                      ((funct3_in == 3'b001) || (funct3_in == 3'b101));

    // The word in flight already owns a slot, so it counts toward the depth limit.
    assign complete     = we_q && imem_ready_in;
    assign full_pending = (32'(count_q) + 32'(we_q)) >= IMEM_DEPTH;
    assign count_nxt    = count_q + CW'(complete);

    assign req_ready_out = !clear_in && !full_pending && (!we_q || imem_ready_in);
    assign accept        = req_valid_in && req_ready_out;

    always_comb begin
        enc_word = '0;
        fmt_ok   = 1'b1;
        case (fmt)
            FMT_R: enc_word = {funct7_in, rs2_in, rs1_in, funct3_in, rd_in, opcode_in};
            FMT_I: begin
                if (is_shift)
                    enc_word = {funct7_in, imm_in[4:0], rs1_in, funct3_in, rd_in, opcode_in};
                else
                    enc_word = {imm_in[11:0], rs1_in, funct3_in, rd_in, opcode_in};
            end
            FMT_S: enc_word = {imm_in[11:5], rs2_in, rs1_in, funct3_in, imm_in[4:0], opcode_in};
            FMT_B: enc_word = {imm_in[12], imm_in[10:5], rs2_in, rs1_in, funct3_in,
                               imm_in[4:1], imm_in[11], opcode_in};
            FMT_U: enc_word = {imm_in[31:12], rd_in, opcode_in};
            FMT_J: enc_word = {imm_in[20], imm_in[10:1], imm_in[11], imm_in[19:12],
                               rd_in, opcode_in};
            default: fmt_ok = 1'b0;
        endcase
    end

`ifdef RISCV_ENCODE_RANGE_CHECK_EN
    // Signed ranges are checked as "upper bits are a pure sign extension".
    always_comb begin
        imm_ok = 1'b1;
        case (fmt)
            FMT_I: imm_ok = is_shift ? (imm_in[31:5] == '0)
                                     : ((&imm_in[31:11]) || !(|imm_in[31:11]));
            FMT_S: imm_ok = (&imm_in[31:11]) || !(|imm_in[31:11]);
            FMT_B: imm_ok = ((&imm_in[31:12]) || !(|imm_in[31:12])) && !imm_in[0];
            FMT_U: imm_ok = (imm_in[11:0] == '0);
            FMT_J: imm_ok = ((&imm_in[31:20]) || !(|imm_in[31:20])) && !imm_in[0];
            default: imm_ok = 1'b1;
        endcase
    end
`else
    assign imm_ok = 1'b1;
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else if (clear_in) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_nxt;
            if (complete)
                we_q <= 1'b0;
            if (accept) begin
                if (fmt_ok && imm_ok) begin
                    we_q   <= 1'b1;
                    addr_q <= count_nxt[AW-1:0];
                    data_q <= enc_word;
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign imem_we_out   = we_q;
    assign imem_addr_out = addr_q;
    assign imem_data_out = data_q;
    assign count_out     = count_q;
    assign full_out      = (32'(count_q) == IMEM_DEPTH);
    assign error_out     = err_q;

endmodule

// File: tb/tb_riscv_encode.sv
// Directed bench for riscv_encode: default-depth instance plus a depth-4 instance
// for the full condition.
module tb_riscv_encode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        valid;
    logic        valid4;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        imem_ready;

    logic        ready, we, full, err;
    logic [11:0] addr;
    logic [31:0] data;
    logic [12:0] count;

    logic        ready4, we4, full4, err4;
    logic [1:0]  addr4;
    logic [31:0] data4;
    logic [2:0]  count4;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_words [5];

    always #5 clk = ~clk;

    riscv_encode dut (
        .clk_in(clk), .rst_n_in(rst_n), .clear_in(clear),
        .req_valid_in(valid), .req_ready_out(ready),
        .fmt_in(fmt), .opcode_in(opcode), .funct3_in(funct3), .funct7_in(funct7),
        .rd_in(rd), .rs1_in(rs1), .rs2_in(rs2), .imm_in(imm),
        .imem_we_out(we), .imem_ready_in(imem_ready),
        .imem_addr_out(addr), .imem_data_out(data),
        .count_out(count), .full_out(full), .error_out(err)
    );

    riscv_encode #(.IMEM_DEPTH(4)) dut4 (
        .clk_in(clk), .rst_n_in(rst_n), .clear_in(clear),
        .req_valid_in(valid4), .req_ready_out(ready4),
        .fmt_in(fmt), .opcode_in(opcode), .funct3_in(funct3), .funct7_in(funct7),
        .rd_in(rd), .rs1_in(rs1), .rs2_in(rs2), .imm_in(imm),
        .imem_we_out(we4), .imem_ready_in(imem_ready),
        .imem_addr_out(addr4), .imem_data_out(data4),
        .count_out(count4), .full_out(full4), .error_out(err4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [31:0] im);
        fmt = f; opcode = op; funct3 = f3; funct7 = f7;
        rd = d; rs1 = s1; rs2 = s2; imm = im;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_words[0] = 32'h002081B3;
        exp_words[1] = 32'h0020A423;
        exp_words[2] = 32'hFE000EE3;
        exp_words[3] = 32'h123452B7;
        exp_words[4] = 32'h008000EF;

        rst_n = 1'b0; clear = 1'b0; valid = 1'b0; valid4 = 1'b0; imem_ready = 1'b1;
        set_fields(3'd0, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0);
        #1;
        check("rst_we", {31'b0, we}, 32'd0);
        check("rst_addr", {20'b0, addr}, 32'd0);
        check("rst_data", data, 32'd0);
        check("rst_count", {19'b0, count}, 32'd0);
        check("rst_full", {31'b0, full}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        step(); step();
        rst_n = 1'b1;
        #1;
        check("rst_ready", {31'b0, ready}, 32'd1);

        // addi x1,x0,5
        set_fields(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
        valid = 1'b1;
        step();
        valid = 1'b0;
        check("addi_we", {31'b0, we}, 32'd1);
        check("addi_addr", {20'b0, addr}, 32'd0);
        check("addi_data", data, 32'h00500093);
        step();
        check("addi_we_drop", {31'b0, we}, 32'd0);
        check("addi_count", {19'b0, count}, 32'd1);

        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_count", {19'b0, count}, 32'd0);

        // Back-to-back bundles, one word per cycle
        for (int unsigned i = 0; i < 5; i++) begin
            case (i)
                0: set_fields(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0);
                1: set_fields(3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8);
                2: set_fields(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC);
                3: set_fields(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000);
                default: set_fields(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd8);
            endcase
            valid = 1'b1;
            step();
            check($sformatf("b2b_we%0d", i), {31'b0, we}, 32'd1);
            check($sformatf("b2b_addr%0d", i), {20'b0, addr}, i);
            check($sformatf("b2b_data%0d", i), data, exp_words[i]);
            check($sformatf("b2b_count%0d", i), {19'b0, count}, i);
        end
        valid = 1'b0;
        step();
        check("b2b_final_count", {19'b0, count}, 32'd5);
        check("b2b_final_we", {31'b0, we}, 32'd0);

        // Backpressure: hold word at addr 5 for 3 cycles, next bundle waits
        imem_ready = 1'b0;
        set_fields(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
        valid = 1'b1;
        step();
        set_fields(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0);
        for (int unsigned c = 0; c < 3; c++) begin
            step();
            check($sformatf("bp_we%0d", c), {31'b0, we}, 32'd1);
            check($sformatf("bp_addr%0d", c), {20'b0, addr}, 32'd5);
            check($sformatf("bp_data%0d", c), data, 32'h00500093);
            check($sformatf("bp_ready%0d", c), {31'b0, ready}, 32'd0);
            check($sformatf("bp_count%0d", c), {19'b0, count}, 32'd5);
        end
        imem_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'b0, ready}, 32'd1);
        step();
        valid = 1'b0;
        check("bp_next_addr", {20'b0, addr}, 32'd6);
        check("bp_next_data", data, 32'h002081B3);
        check("bp_next_count", {19'b0, count}, 32'd6);
        step();
        check("bp_done_count", {19'b0, count}, 32'd7);

        // addi with imm=2048
        set_fields(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048);
        valid = 1'b1;
        step();
        valid = 1'b0;
`ifdef RISCV_ENCODE_RANGE_CHECK_EN
        check("range_we", {31'b0, we}, 32'd0);
        check("range_err", {31'b0, err}, 32'd1);
        check("range_count", {19'b0, count}, 32'd7);
`else
        check("trunc_we", {31'b0, we}, 32'd1);
        check("trunc_addr", {20'b0, addr}, 32'd7);
        check("trunc_data", data, 32'h80000093);
        check("trunc_err", {31'b0, err}, 32'd0);
`endif
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr2_err", {31'b0, err}, 32'd0);
        check("clr2_count", {19'b0, count}, 32'd0);
        check("clr2_full", {31'b0, full}, 32'd0);

        // Invalid format
        set_fields(3'd7, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
        valid = 1'b1;
        step();
        valid = 1'b0;
        check("badfmt_we", {31'b0, we}, 32'd0);
        check("badfmt_err", {31'b0, err}, 32'd1);
        check("badfmt_count", {19'b0, count}, 32'd0);
        step();
        check("badfmt_sticky", {31'b0, err}, 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;

        // Reset during a pending write
        set_fields(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
        valid = 1'b1;
        step();
        valid = 1'b0;
        step();
        check("pre_rst_count", {19'b0, count}, 32'd1);
        imem_ready = 1'b0;
        valid = 1'b1;
        step();
        valid = 1'b0;
        check("pre_rst_we", {31'b0, we}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_we", {31'b0, we}, 32'd0);
        check("async_rst_count", {19'b0, count}, 32'd0);
        check("async_rst_addr", {20'b0, addr}, 32'd0);
        check("async_rst_data", data, 32'd0);
        step();
        rst_n = 1'b1;
        imem_ready = 1'b1;

        // Depth-4 instance fills and stops
        valid4 = 1'b1;
        for (int unsigned k = 0; k < 4; k++) begin
            step();
            check($sformatf("d4_addr%0d", k), {30'b0, addr4}, k);
        end
        check("d4_ready_last", {31'b0, ready4}, 32'd0);
        step();
        check("d4_count_full", {29'b0, count4}, 32'd4);
        check("d4_full", {31'b0, full4}, 32'd1);
        check("d4_ready_full", {31'b0, ready4}, 32'd0);
        step();
        check("d4_no_fifth_we", {31'b0, we4}, 32'd0);
        check("d4_no_fifth_count", {29'b0, count4}, 32'd4);
        valid4 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
